host_lcd_writer: RTL and testbench
==================================

# host_lcd_writer

Drives the 256-bit two-row host display image onto a 16x2 HD44780-compatible character LCD over its 8-bit parallel bus. It is the consumer of the display image the host game display logic produces:
- Top row is `disp[255:128]`, bottom row is `disp[127:0]`, one ASCII byte per character cell.
- After power-up it runs the LCD initialisation sequence.
- It then rewrites both rows whenever a refresh is requested, so the panel tracks the game state without the game logic knowing LCD timing.

## Interface
- `EN_CYCLES`, 12: cycles `lcdEn` is held high per byte.
- `CMD_WAIT`, 2000: cycles `lcdEn` stays low after each byte (execution time).
- `CLR_WAIT`, 80000: post-byte wait used instead of `CMD_WAIT` for the clear command 0x01.
- `INIT_WAIT`, 800000: power-up wait after reset before the first command.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `disp`  in  256  display image. Character i of the top row is `disp[255-8i -: 8]`; character i of the bottom row is `disp[127-8i -: 8]`.
- `update`  in  1  single-cycle refresh request.
- `ready`  out  1  high only in IDLE with no pending request.
- `lcdRs`  out  1  register select: 0 = command, 1 = data.
- `lcdRw`  out  1  tied 0 (write only).
- `lcdEn`  out  1  LCD enable strobe.
- `lcdData`  out  8  LCD data bus.

## Operation
- **Reset values:** `lcdRs`=0, `lcdRw`=0, `lcdEn`=0, `lcdData`=0x00, `ready`=0. The pending flag and all counters are cleared, and the state is POWERUP.
- **States:** POWERUP → INIT → IDLE → ROW0 → ROW1 → IDLE.
  - POWERUP: counts `INIT_WAIT` cycles with outputs at their reset values, then enters INIT.
  - INIT: commands 0x38 (8-bit, 2 lines), 0x0C (display on, cursor off), 0x06 (increment), 0x01 (clear), in that order, then IDLE.
  - ROW0: command 0x80, then 16 data bytes of the top row, char 0 first.
  - ROW1: command 0xC0, then 16 data bytes of the bottom row, char 0 first. Returns to IDLE.
- **Byte transfer (sub-sequence):**
  - SETUP, 1 cycle: `lcdRs`/`lcdData` driven, `lcdEn`=0.
  - PULSE, `EN_CYCLES` cycles: `lcdEn`=1.
  - WAIT, `CMD_WAIT` cycles (`CLR_WAIT` for 0x01): `lcdEn`=0.
  - `lcdRs`/`lcdData` are held stable from SETUP through the end of WAIT.
- **Pending flag:** `update`=1 in any state sets it. Leaving IDLE into ROW0 clears it. Multiple requests while busy coalesce into one refresh.
- **Snapshot:** `disp` is copied into an internal 256-bit snapshot on the cycle the FSM leaves IDLE. Changes to `disp` during a refresh do not affect the bytes written in that refresh.
- **Requests during POWERUP/INIT:** held pending and serviced immediately after INIT.
- **Reset mid-transfer:** `lcdEn` drops to 0 on the next edge and the full POWERUP/INIT sequence repeats.

## Timing
- Byte period T = 1 + `EN_CYCLES` + `CMD_WAIT`. Clear byte period = 1 + `EN_CYCLES` + `CLR_WAIT`.
- Init duration after reset release = `INIT_WAIT` + 3T + clear period. `ready` rises on the following cycle if nothing is pending.
- IDLE with pending set: SETUP of 0x80 is the next cycle (1 cycle latency from IDLE). `ready` falls in the same cycle.
- A full refresh is 34 bytes = 34T cycles. The IDLE re-entry cycle follows the last WAIT.
- `update` asserted in the last WAIT cycle of a refresh: the FSM passes through IDLE for exactly 1 cycle, with `ready`=0, then starts the next refresh.

## Configuration
- `HOST_LCD_AUTO_REFRESH_EN`:
  - **Defined:** the block keeps a 256-bit copy of the last image written. In IDLE, when `disp` differs from that copy, it sets pending exactly as `update` does.
  - **Not defined:** refresh starts only from `update`, and the comparator and copy register are absent.
- In both builds `update` remains functional.

## Test plan
All scenarios use `EN_CYCLES`=2, `CMD_WAIT`=4, `CLR_WAIT`=20, `INIT_WAIT`=10, so T=7.
- **Reset/init:** release `rst`.
  - Outputs stay at reset values for 10 cycles.
  - Bytes 0x38, 0x0C, 0x06, 0x01 follow, with `lcdRs`=0 and 2-cycle `lcdEn` pulses.
  - `ready`=1 at cycle 10+21+23 after release.
- **Refresh:** `disp` top row = "HANGMAN", padded with 0x20; bottom row = "X_X_X_", padded with 0x20; pulse `update`.
  - Byte sequence: 0x80, 'H','A','N','G','M','A','N', 9×0x20, 0xC0, 'X','_','X','_','X','_', 10×0x20.
  - `lcdRs`=0 only on the two address bytes. Refresh completes in 238 cycles.
- **Snapshot:** change `disp` to all 0x41 during byte 5 of a refresh.
  - The remaining bytes still come from the original image.
- **Coalescing:** pulse `update` three times during a refresh.
  - Exactly one further refresh, with 1 IDLE cycle between refreshes and `ready`=0 throughout.
- **Mid-refresh reset:** assert `rst` during PULSE.
  - `lcdEn`=0 on the next edge, `ready`=0, and the init sequence replays from POWERUP.
- **Auto refresh (`HOST_LCD_AUTO_REFRESH_EN`):** in IDLE, change one character of `disp` with no `update`.
  - A refresh starts the next cycle.
  - With `disp` unchanged afterwards, no further refresh occurs.
  - Without the macro, the same stimulus produces no bus activity.

Source files
------------

// File: rtl/host_lcd_writer.sv
// Streams a 256-bit two-row display image onto a 16x2 HD44780 LCD over its 8-bit bus.
// Optional HOST_LCD_AUTO_REFRESH_EN: refresh automatically when the image differs from the one last written.
module host_lcd_writer #(
   parameter int unsigned EN_CYCLES = 12,
   parameter int unsigned CMD_WAIT  = 2000,
   parameter int unsigned CLR_WAIT  = 80000,
   parameter int unsigned INIT_WAIT = 800000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] disp,
   input  logic         update,
   output logic         ready,
   output logic         lcdRs,
   output logic         lcdRw,
   output logic         lcdEn,
   output logic [7:0]   lcdData
);

   typedef enum logic [2:0] {ST_POWERUP, ST_INIT, ST_IDLE, ST_ROW0, ST_ROW1} state_t;
   typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

   state_t         state_q, state_d;
   phase_t         phase_q, phase_d;
   logic [4:0]     idx_q, idx_d;
   logic [31:0]    cnt_q, cnt_d;
   logic           pend_q, pend_d;
   logic [255:0]   snap_q, snap_d;

   logic [127:0]   rowBits;
   logic [3:0]     charSel;
   logic           curRs;
   logic [7:0]     curByte;
   logic           active;
   logic           lastByte;
   logic           imageChanged;
   logic [31:0]    waitLen;

   // The snapshot doubles as the copy of the last image written, so the comparator only needs disp.
`ifdef HOST_LCD_AUTO_REFRESH_EN
   assign imageChanged = (state_q == ST_IDLE) && (disp != snap_q);
`else
   assign imageChanged = 1'b0;
`endif

   always_comb begin
      rowBits = (state_q == ST_ROW0) ? snap_q[255:128] : snap_q[127:0];
      charSel = idx_q[3:0] - 4'd1;
      curRs   = 1'b0;
      curByte = 8'h00;
      case (state_q)
         ST_INIT: begin
            case (idx_q[1:0])
               2'd0:    curByte = 8'h38;
               2'd1:    curByte = 8'h0C;
               2'd2:    curByte = 8'h06;
               default: curByte = 8'h01;
            endcase
         end
         ST_ROW0, ST_ROW1: begin
            if (idx_q == 5'd0) begin
               curByte = (state_q == ST_ROW0) ? 8'h80 : 8'hC0;
            end else begin
               curRs   = 1'b1;
               curByte = rowBits[{~charSel, 3'b000} +: 8];
            end
         end
         default: ;
      endcase
   end

   assign active   = (state_q == ST_INIT) || (state_q == ST_ROW0) || (state_q == ST_ROW1);
   assign lastByte = (state_q == ST_INIT) ? (idx_q == 5'd3) : (idx_q == 5'd16);
   assign waitLen  = (!curRs && curByte == 8'h01) ? CLR_WAIT : CMD_WAIT;

   // Leaving IDLE keeps only a request arriving in that same cycle, since it postdates the snapshot.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + 32'd1;
      pend_d  = pend_q | update | imageChanged;
      snap_d  = snap_q;
      case (state_q)
         ST_POWERUP: begin
            if (cnt_q == INIT_WAIT - 1) begin
               state_d = ST_INIT;
               phase_d = PH_SETUP;
               idx_d   = '0;
               cnt_d   = '0;
            end
         end
         ST_IDLE: begin
            cnt_d = '0;
            if (pend_q) begin
               state_d = ST_ROW0;
               phase_d = PH_SETUP;
               idx_d   = '0;
               pend_d  = update;
               snap_d  = disp;
            end
         end
         ST_INIT, ST_ROW0, ST_ROW1: begin
            case (phase_q)
               PH_SETUP: begin
                  phase_d = PH_PULSE;
                  cnt_d   = '0;
               end
               PH_PULSE: begin
                  if (cnt_q == EN_CYCLES - 1) begin
                     phase_d = PH_WAIT;
                     cnt_d   = '0;
                  end
               end
               PH_WAIT: begin
                  if (cnt_q == waitLen - 32'd1) begin
                     phase_d = PH_SETUP;
                     cnt_d   = '0;
                     if (!lastByte) begin
                        idx_d = idx_q + 5'd1;
                     end else begin
                        idx_d = '0;
                        case (state_q)
                           ST_ROW0: state_d = ST_ROW1;
                           default: state_d = ST_IDLE;
                        endcase
                     end
                  end
               end
               default: phase_d = PH_SETUP;
            endcase
         end
         default: state_d = ST_POWERUP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_POWERUP;
         phase_q <= PH_SETUP;
         idx_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         snap_q  <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         snap_q  <= snap_d;
      end
   end

   // Bus fields come straight from registered state, so they stay put for a whole byte period.
   assign ready   = (state_q == ST_IDLE) && !pend_q;
   assign lcdRw   = 1'b0;
   assign lcdEn   = active && (phase_q == PH_PULSE);
   assign lcdRs   = active && curRs;
   assign lcdData = active ? curByte : 8'h00;

endmodule

// File: tb/tb_host_lcd_writer.sv
// Scoreboard bench for host_lcd_writer: expected LCD bytes are queued from an image-level model
// and a bus monitor pops and compares them on every enable strobe.
`timescale 1ns/1ps
module tb_host_lcd_writer;

   localparam int unsigned EN  = 2;
   localparam int unsigned CW  = 4;
   localparam int unsigned CLR = 20;
   localparam int unsigned IW  = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         update = 1'b0;
   logic [255:0] disp = '0;
   logic         ready;
   logic         lcdRs;
   logic         lcdRw;
   logic         lcdEn;
   logic [7:0]   lcdData;

   host_lcd_writer #(
      .EN_CYCLES(EN),
      .CMD_WAIT (CW),
      .CLR_WAIT (CLR),
      .INIT_WAIT(IW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .disp   (disp),
      .update (update),
      .ready  (ready),
      .lcdRs  (lcdRs),
      .lcdRw  (lcdRw),
      .lcdEn  (lcdEn),
      .lcdData(lcdData)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } busByte_t;

   busByte_t expQ[$];
   int       riseLog[$];
   int       cyc = 0;
   int       asserts = 0;
   int       failures = 0;

   // Free-running cycle index used to timestamp enable strobes.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      asserts++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic failNow(input string name, input string what);
      asserts++;
      failures++;
      $display("[TB] FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   // Reference model: the byte stream the panel should receive, built from the image alone.
   function automatic logic [127:0] textRow(input string s);
      logic [127:0] r;
      r = {16{8'h20}};
      for (int i = 0; i < 16 && i < s.len(); i++) r[127-8*i -: 8] = s[i];
      return r;
   endfunction

   task automatic pushByte(input logic rs, input logic [7:0] d);
      busByte_t b;
      b.rs   = rs;
      b.data = d;
      expQ.push_back(b);
   endtask

   task automatic expectInit();
      pushByte(1'b0, 8'h38);
      pushByte(1'b0, 8'h0C);
      pushByte(1'b0, 8'h06);
      pushByte(1'b0, 8'h01);
   endtask

   task automatic expectRefresh(input logic [255:0] img);
      pushByte(1'b0, 8'h80);
      for (int i = 0; i < 16; i++) pushByte(1'b1, img[255-8*i -: 8]);
      pushByte(1'b0, 8'hC0);
      for (int i = 0; i < 16; i++) pushByte(1'b1, img[127-8*i -: 8]);
   endtask

   function automatic logic [255:0] randomImage();
      logic [255:0] img;
      for (int w = 0; w < 8; w++) img[32*w +: 32] = $urandom();
      return img;
   endfunction

   // Bus monitor: on each enable rising edge it pops the scoreboard; on each falling edge it checks width and hold.
   initial begin : monitor
      busByte_t   e;
      logic       prevEn;
      logic [8:0] prevBus;
      logic [8:0] heldBus;
      int         enHigh;
      prevEn  = 1'b0;
      prevBus = '0;
      heldBus = '0;
      enHigh  = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prevEn = 1'b0;
            enHigh = 0;
         end else begin
            if (lcdEn && !prevEn) begin
               riseLog.push_back(cyc);
               checkOutput("setupBeforeEnable", {23'd0, prevBus}, {23'd0, lcdRs, lcdData});
               if (expQ.size() == 0) begin
                  failNow("busByte", $sformatf("unexpected byte rs=%0b data=0x%02h, want none", lcdRs, lcdData));
               end else begin
                  e = expQ.pop_front();
                  checkOutput("busByte", {22'd0, lcdRw, lcdRs, lcdData}, {22'd0, 1'b0, e.rs, e.data});
               end
               heldBus = {lcdRs, lcdData};
               enHigh  = 1;
            end else if (lcdEn) begin
               enHigh++;
            end else if (prevEn) begin
               checkOutput("enableWidth", enHigh, EN);
               checkOutput("busHeld", {23'd0, lcdRs, lcdData}, {23'd0, heldBus});
            end
            prevEn = lcdEn;
         end
         prevBus = {lcdRs, lcdData};
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus();
      update = 1'b1;
      tick();
      update = 1'b0;
   endtask

   task automatic waitReady(input int bound, input string name);
      int n;
      n = 0;
      while (!ready && n < bound) begin
         tick();
         n++;
      end
      if (!ready) failNow(name, "ready never rose within bound");
   endtask

   task automatic waitRises(input int target, input string name);
      int n;
      n = 0;
      while (riseLog.size() < target && n < 600) begin
         tick();
         n++;
      end
      if (riseLog.size() < target) failNow(name, "enable strobe never arrived within bound");
   endtask

   // Releases reset and checks the power-up quiet period and the four init commands.
   task automatic initSequence();
      int base, r0, mism;
      checkOutput("resetOutputs", {20'd0, ready, lcdRw, lcdEn, lcdRs, lcdData}, 32'd0);
      expectInit();
      r0   = riseLog.size();
      rst  = 1'b0;
      base = cyc;
      mism = 0;
      for (int c = 0; c < int'(IW); c++) begin
         if ({ready, lcdEn, lcdRs, lcdData} !== 11'd0) mism++;
         tick();
      end
      checkOutput("powerupQuiet", mism, 0);
      waitReady(200, "initReady");
      checkOutput("initToReady", cyc - base, 54);
      if (riseLog.size() >= r0 + 4) begin
         checkOutput("firstCmdEnable", riseLog[r0] - base, 11);
         checkOutput("clearCmdEnable", riseLog[r0+3] - base, 32);
      end else begin
         failNow("initStrobes", "fewer than four init strobes");
      end
      checkOutput("initDrained", expQ.size(), 0);
   endtask

   // One refresh from IDLE: update is seen in cycle 0, SETUP of 0x80 in cycle 2, IDLE again at 2 + 34*7.
   task automatic runRefresh(input logic [255:0] img);
      int base, r0, mism;
      disp = img;
      expectRefresh(img);
      r0   = riseLog.size();
      base = cyc;
      applyStimulus();
      checkOutput("readyFalls", ready, 0);
      waitReady(1000, "refreshReady");
      checkOutput("refreshDuration", cyc - base, 240);
      if (riseLog.size() >= r0 + 34) begin
         checkOutput("refreshFirstEnable", riseLog[r0] - base, 3);
         mism = 0;
         for (int k = r0; k < r0 + 33; k++) if (riseLog[k+1] - riseLog[k] != 7) mism++;
         checkOutput("byteSpacing", mism, 0);
      end else begin
         failNow("refreshStrobes", "fewer than 34 strobes");
      end
      checkOutput("refreshDrained", expQ.size(), 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      logic [255:0] img;
      int base, r0;
      repeat (3) tick();
      initSequence();

      $display("[TB] fixed HANGMAN refresh");
      runRefresh({textRow("HANGMAN"), textRow("X_X_X_")});

      $display("[TB] randomized refreshes");
      for (int it = 0; it < 3; it++) begin
         repeat ($urandom_range(5, 0)) tick();
         runRefresh(randomImage());
      end

      $display("[TB] snapshot isolation");
      img  = randomImage();
      disp = img;
      expectRefresh(img);
      r0   = riseLog.size();
      applyStimulus();
      waitRises(r0 + 5, "snapshotByte5");
      disp = {32{8'h41}};
      waitReady(1000, "snapshotReady");
`ifdef HOST_LCD_AUTO_REFRESH_EN
      expectRefresh({32{8'h41}});
      repeat (2) tick();
      waitReady(1000, "snapshotAutoReady");
`endif
      checkOutput("snapshotDrained", expQ.size(), 0);

      $display("[TB] request coalescing");
      expectRefresh(disp);
      expectRefresh(disp);
      r0   = riseLog.size();
      base = cyc;
      applyStimulus();
      for (int k = 0; k < 3; k++) begin
         repeat ($urandom_range(60, 20)) tick();
         applyStimulus();
      end
      waitReady(1200, "coalesceReady");
      checkOutput("coalescedDuration", cyc - base, 479);
      if (riseLog.size() >= r0 + 35) checkOutput("refreshGap", riseLog[r0+34] - riseLog[r0+33], 8);
      else failNow("refreshGap", "second refresh missing");
      r0 = riseLog.size();
      repeat (30) tick();
      checkOutput("noExtraRefresh", riseLog.size() - r0, 0);
      checkOutput("coalesceDrained", expQ.size(), 0);

      $display("[TB] reset during enable pulse");
      img  = randomImage();
      disp = img;
      expectRefresh(img);
      r0   = riseLog.size();
      applyStimulus();
      waitRises(r0 + 3, "midResetByte3");
      checkOutput("midPulseEnable", lcdEn, 1);
      rst = 1'b1;
      tick();
      checkOutput("resetDropsEnable", lcdEn, 0);
      checkOutput("resetReadyLow", ready, 0);
      expQ.delete();
      disp = '0;
      tick();
      initSequence();

      $display("[TB] image change without update");
      img = disp;
      img[255-8*3 -: 8] = 8'h5A;
      r0 = riseLog.size();
`ifdef HOST_LCD_AUTO_REFRESH_EN
      expectRefresh(img);
      disp = img;
      base = cyc;
      tick();
      checkOutput("autoPending", ready, 0);
      waitReady(1000, "autoReady");
      checkOutput("autoDuration", cyc - base, 240);
      r0 = riseLog.size();
      repeat (40) tick();
      checkOutput("autoNoRepeat", riseLog.size() - r0, 0);
      checkOutput("autoDrained", expQ.size(), 0);
`else
      disp = img;
      repeat (40) tick();
      checkOutput("noAutoActivity", riseLog.size() - r0, 0);
      checkOutput("noAutoReady", ready, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
